// File: rtl/rv32i_fetch_ctrl_pkg.sv
// Shared types and constants for the rv32i prefetch sequencer and its perf counters.
package rv32i_fetch_ctrl_pkg;

    localparam int STATE_W    = 2;
    localparam int PERF_CNT_W = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // rv32i without the C extension needs word-aligned fetch targets.
    function automatic logic misaligned(input logic [1:0] addr_lsb);
        return |addr_lsb;
    endfunction

endpackage

// File: rtl/rv32i_fetch_ctrl_if.sv
// Control/status bundle between execute/hazard logic, the fetch sequencer and prefetch.
interface rv32i_fetch_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int STAGES = 4
);
    import rv32i_fetch_ctrl_pkg::*;

    logic                  stall;
    logic                  branch_taken;
    logic [XLEN-1:0]       branch_target;
    logic                  trap;
    logic [XLEN-1:0]       trap_vector;
    logic                  halt;
    logic                  resume;
    logic                  advance;
    logic                  pc_write;
    logic [XLEN-1:0]       pc;
    logic [STAGES-1:0]     valid;
    logic                  halted;
    logic                  fault;
    logic [XLEN-1:0]       fault_pc;
    logic [PERF_CNT_W-1:0] stall_cnt;

    // master: the sequencer itself
    modport master (
        input  stall, branch_taken, branch_target, trap, trap_vector, halt, resume,
        output advance, pc_write, pc, valid, halted, fault, fault_pc, stall_cnt
    );

    // slave: the surrounding pipeline
    modport slave (
        output stall, branch_taken, branch_target, trap, trap_vector, halt, resume,
        input  advance, pc_write, pc, valid, halted, fault, fault_pc, stall_cnt
    );

endinterface

// File: rtl/rv32i_perf_counter.sv
// Free-running event counter with synchronous clear; wraps at full scale.
module rv32i_perf_counter
    import rv32i_fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = PERF_CNT_W
) (
    input  logic             clk_i,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk_i) begin
        if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/rv32i_fetch_ctrl.sv
// Prefetch sequencer: boot/run/halt FSM, redirect mux, per-stage valid tracking
// with wrong-path squash, sticky misaligned-target fault and stall-cycle counter.
module rv32i_fetch_ctrl
    import rv32i_fetch_ctrl_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              STAGES       = 4,
    parameter int              REDIRECT_STG = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    rv32i_fetch_ctrl_if.master bus
);

    fetch_state_e      state_reg, state_next;
    logic [STAGES-1:0] valid_reg, valid_next;
    logic              fault_reg, fault_next;
    logic [XLEN-1:0]   fault_pc_reg, fault_pc_next;

    logic [STAGES-1:0] shift_vld;
    logic [STAGES-1:0] squash_mask;
    logic [XLEN-1:0]   target;
    logic              redirect;
    logic              bad_target;
    logic              stall_cnt_en;
    logic              advance_raw;
    logic              pc_write_raw;
    logic [XLEN-1:0]   pc_raw;

    // Stages 1..REDIRECT_STG hold instructions younger than the redirecting one.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_squash
            assign squash_mask[gi] = (gi >= 1) && (gi <= REDIRECT_STG);
        end
    endgenerate

    assign redirect   = bus.trap | bus.branch_taken;
    assign target     = bus.trap ? bus.trap_vector : bus.branch_target;
    assign bad_target = misaligned(target[1:0]);
    assign shift_vld  = {valid_reg[STAGES-2:0], 1'b1};

    always_comb begin
        state_next    = state_reg;
        valid_next    = valid_reg;
        fault_next    = fault_reg;
        fault_pc_next = fault_pc_reg;
        advance_raw   = 1'b0;
        pc_write_raw  = 1'b0;
        pc_raw        = '0;
        stall_cnt_en  = 1'b0;

        case (state_reg)
            ST_BOOT: begin
                advance_raw  = 1'b1;
                pc_write_raw = 1'b1;
                pc_raw       = RESET_VECTOR;
                valid_next   = shift_vld;
                state_next   = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    if (bad_target) begin
                        fault_next    = 1'b1;
                        fault_pc_next = target;
                        valid_next    = '0;
                        state_next    = ST_HALT;
                    end else begin
                        // Redirect wins over back-pressure and is not a counted stall.
                        advance_raw  = 1'b1;
                        pc_write_raw = 1'b1;
                        pc_raw       = target;
                        valid_next   = shift_vld & ~squash_mask;
                        state_next   = bus.halt ? ST_HALT : ST_RUN;
                    end
                end else begin
                    advance_raw = ~bus.stall;
                    if (bus.stall) begin
                        stall_cnt_en = 1'b1;
                    end else begin
                        valid_next = shift_vld;
                    end
                    state_next = bus.halt ? ST_HALT : ST_RUN;
                end
            end
            ST_HALT: begin
                if (bus.resume && !bus.halt && !fault_reg) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg    <= ST_BOOT;
            valid_reg    <= '0;
            fault_reg    <= 1'b0;
            fault_pc_reg <= '0;
        end else begin
            state_reg    <= state_next;
            valid_reg    <= valid_next;
            fault_reg    <= fault_next;
            fault_pc_reg <= fault_pc_next;
        end
    end

    rv32i_perf_counter #(
        .WIDTH (PERF_CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .clr   (~rst_n_i),
        .en    (stall_cnt_en),
        .count (bus.stall_cnt)
    );

    // Strobes are forced quiet while reset is held, whatever the state register holds.
    assign bus.advance  = rst_n_i & advance_raw;
    assign bus.pc_write = rst_n_i & pc_write_raw;
    assign bus.pc       = rst_n_i ? pc_raw : '0;
    assign bus.valid    = valid_reg;
    assign bus.halted   = (state_reg == ST_HALT);
    assign bus.fault    = fault_reg;
    assign bus.fault_pc = fault_pc_reg;

endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// Self-checking bench for rv32i_fetch_ctrl: directed scenarios plus randomized
// traffic against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_rv32i_fetch_ctrl;

    localparam int          XLEN   = 32;
    localparam int          STAGES = 4;
    localparam int          RSTG   = 2;
    localparam logic [31:0] RVEC   = 32'h0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv32i_fetch_ctrl_if #(.XLEN(XLEN), .STAGES(STAGES)) bus ();

    rv32i_fetch_ctrl #(
        .XLEN         (XLEN),
        .STAGES       (STAGES),
        .REDIRECT_STG (RSTG),
        .RESET_VECTOR (RVEC)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // inputs applied this cycle
    logic        i_rst_n, i_stall, i_br, i_trap, i_halt, i_res;
    logic [31:0] i_tgt, i_vec;

    // behavioural model
    bit        m_boot, m_halted, m_fault;
    bit [31:0] m_fpc, m_cnt;
    bit        m_valid [STAGES];
    bit        e_adv, e_pw;
    bit [31:0] e_pc;

    function automatic logic [STAGES-1:0] m_valid_vec();
        logic [STAGES-1:0] v;
        for (int s = 0; s < STAGES; s++) v[s] = m_valid[s];
        return v;
    endfunction

    function automatic void predict();
        bit [31:0] dest;
        dest  = i_trap ? i_vec : i_tgt;
        e_adv = 1'b0;
        e_pw  = 1'b0;
        e_pc  = 32'h0;
        if (!i_rst_n) begin
        end else if (m_boot) begin
            e_adv = 1'b1; e_pw = 1'b1; e_pc = RVEC;
        end else if (m_halted) begin
        end else if (i_trap || i_br) begin
            if (dest % 4 == 0) begin
                e_adv = 1'b1; e_pw = 1'b1; e_pc = dest;
            end
        end else begin
            e_adv = !i_stall;
        end
    endfunction

    function automatic void model_update();
        bit [31:0] dest;
        bit        nv [STAGES];
        dest = i_trap ? i_vec : i_tgt;
        for (int s = STAGES - 1; s > 0; s--) nv[s] = m_valid[s-1];
        nv[0] = 1'b1;
        if (!i_rst_n) begin
            m_boot = 1; m_halted = 0; m_fault = 0; m_fpc = 0; m_cnt = 0;
            for (int s = 0; s < STAGES; s++) m_valid[s] = 0;
        end else if (m_boot) begin
            m_boot = 0;
            for (int s = 0; s < STAGES; s++) m_valid[s] = (s == 0);
        end else if (m_halted) begin
            if (i_res && !i_halt && !m_fault) m_halted = 0;
        end else if (i_trap || i_br) begin
            if (dest % 4 != 0) begin
                m_fault = 1; m_fpc = dest; m_halted = 1;
                for (int s = 0; s < STAGES; s++) m_valid[s] = 0;
            end else begin
                for (int s = 0; s < STAGES; s++) m_valid[s] = (s >= 1 && s <= RSTG) ? 1'b0 : nv[s];
                m_halted = i_halt;
            end
        end else begin
            if (i_stall) m_cnt = m_cnt + 1;
            else for (int s = 0; s < STAGES; s++) m_valid[s] = nv[s];
            m_halted = i_halt;
        end
    endfunction

    task automatic apply(input logic rn, input logic st, input logic br, input logic tr,
                         input logic ht, input logic rs, input logic [31:0] tgt, input logic [31:0] vec);
        i_rst_n = rn; i_stall = st; i_br = br; i_trap = tr; i_halt = ht; i_res = rs;
        i_tgt = tgt; i_vec = vec;
        rst_n             = rn;
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.trap          = tr;
        bus.halt          = ht;
        bus.resume        = rs;
        bus.branch_target = tgt;
        bus.trap_vector   = vec;
        #1;
        predict();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic test_reset();
        logic [3:0] fill [4];
        fill = '{4'h1, 4'h3, 4'h7, 4'hF};
        apply(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        checks++;
        if (bus.advance !== 1'b0 || bus.pc_write !== 1'b0 || bus.pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_strobes: adv=%0b pw=%0b pc=%h, required 0 0 00000000", bus.advance, bus.pc_write, bus.pc);
        end
        tick();
        tick();
        checks++;
        if (bus.valid !== 4'h0 || bus.halted !== 1'b0 || bus.fault !== 1'b0 ||
            bus.fault_pc !== 32'h0 || bus.stall_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: valid=%b halted=%0b fault=%0b fpc=%h cnt=%0d, required all zero",
                     bus.valid, bus.halted, bus.fault, bus.fault_pc, bus.stall_cnt);
        end
        apply(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        checks++;
        if (bus.pc_write !== 1'b1 || bus.pc !== RVEC || bus.advance !== 1'b1) begin
            errors++;
            $display("FAIL boot_strobe: pw=%0b pc=%h adv=%0b, required 1 %h 1", bus.pc_write, bus.pc, bus.advance, RVEC);
        end
        $display("txn reset release: pc_write=%0b pc=%h", bus.pc_write, bus.pc);
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.valid !== fill[k]) begin
                errors++;
                $display("FAIL fill_valid[%0d]: got %b, required %b", k, bus.valid, fill[k]);
            end
            $display("txn fill %0d: valid=%b", k, bus.valid);
            if (k < 3) begin
                apply(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
                checks++;
                if (bus.advance !== 1'b1 || bus.pc_write !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_adv[%0d]: adv=%0b pw=%0b, required 1 0", k, bus.advance, bus.pc_write);
                end
                tick();
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            apply(1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
            checks++;
            if (bus.advance !== 1'b0) begin
                errors++;
                $display("FAIL stall_adv[%0d]: got %0b, required 0", k, bus.advance);
            end
            tick();
            checks++;
            if (bus.valid !== 4'hF) begin
                errors++;
                $display("FAIL stall_valid[%0d]: got %b, required 1111", k, bus.valid);
            end
        end
        checks++;
        if (bus.stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL stall_cnt: got %0d, required 3", bus.stall_cnt);
        end
        $display("txn stall x3: stall_cnt=%0d", bus.stall_cnt);
    endtask

    task automatic test_branch();
        apply(1, 1, 1, 0, 0, 0, 32'h40, 32'h0);
        checks++;
        if (bus.advance !== 1'b1 || bus.pc_write !== 1'b1 || bus.pc !== 32'h40) begin
            errors++;
            $display("FAIL branch_strobe: adv=%0b pw=%0b pc=%h, required 1 1 00000040", bus.advance, bus.pc_write, bus.pc);
        end
        tick();
        checks++;
        if (bus.valid !== 4'b1001 || bus.stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL branch_squash: valid=%b cnt=%0d, required 1001 3", bus.valid, bus.stall_cnt);
        end
        $display("txn branch 0x40 under stall: valid=%b", bus.valid);
    endtask

    task automatic test_trap_priority();
        apply(1, 0, 1, 1, 0, 0, 32'h40, 32'h100);
        checks++;
        if (bus.pc !== 32'h100 || bus.pc_write !== 1'b1) begin
            errors++;
            $display("FAIL trap_priority: pc=%h pw=%0b, required 00000100 1", bus.pc, bus.pc_write);
        end
        tick();
        checks++;
        if (bus.valid !== m_valid_vec()) begin
            errors++;
            $display("FAIL trap_valid: got %b, required %b", bus.valid, m_valid_vec());
        end
        $display("txn trap+branch: valid=%b", bus.valid);
    endtask

    task automatic test_misaligned();
        apply(1, 0, 1, 0, 0, 0, 32'h42, 32'h0);
        checks++;
        if (bus.pc_write !== 1'b0 || bus.advance !== 1'b0 || bus.pc !== 32'h0) begin
            errors++;
            $display("FAIL misalign_strobe: pw=%0b adv=%0b pc=%h, required 0 0 00000000", bus.pc_write, bus.advance, bus.pc);
        end
        tick();
        checks++;
        if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h42 || bus.halted !== 1'b1 || bus.valid !== 4'h0) begin
            errors++;
            $display("FAIL misalign_fault: fault=%0b fpc=%h halted=%0b valid=%b, required 1 00000042 1 0000",
                     bus.fault, bus.fault_pc, bus.halted, bus.valid);
        end
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
            checks++;
            if (bus.advance !== 1'b0) begin
                errors++;
                $display("FAIL fault_resume_adv[%0d]: got %0b, required 0", k, bus.advance);
            end
            tick();
            checks++;
            if (bus.halted !== 1'b1 || bus.fault !== 1'b1) begin
                errors++;
                $display("FAIL fault_resume_ignored[%0d]: halted=%0b fault=%0b, required 1 1", k, bus.halted, bus.fault);
            end
        end
        $display("txn misaligned 0x42: fault=%0b halted=%0b", bus.fault, bus.halted);
    endtask

    task automatic test_halt_resume();
        bit [31:0] cnt_before;
        apply(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        apply(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
            tick();
        end
        apply(1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        cnt_before = m_cnt;
        apply(1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
        checks++;
        if (bus.advance !== 1'b1) begin
            errors++;
            $display("FAIL halt_cycle_adv: got %0b, required 1", bus.advance);
        end
        tick();
        for (int k = 0; k < 5; k++) begin
            apply(1, 1, 1, k[0], 0, 0, 32'h80, 32'h200);
            checks++;
            if (bus.advance !== 1'b0 || bus.pc_write !== 1'b0 || bus.halted !== 1'b1) begin
                errors++;
                $display("FAIL halt_hold[%0d]: adv=%0b pw=%0b halted=%0b, required 0 0 1", k, bus.advance, bus.pc_write, bus.halted);
            end
            tick();
            checks++;
            if (bus.valid !== m_valid_vec() || bus.stall_cnt !== cnt_before) begin
                errors++;
                $display("FAIL halt_state[%0d]: valid=%b cnt=%0d, required %b %0d", k, bus.valid, bus.stall_cnt, m_valid_vec(), cnt_before);
            end
        end
        apply(1, 0, 0, 0, 1, 1, 32'h0, 32'h0);
        tick();
        checks++;
        if (bus.halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_and_resume: halted=%0b, required 1", bus.halted);
        end
        apply(1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
        tick();
        checks++;
        if (bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL resume: halted=%0b, required 0", bus.halted);
        end
        apply(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        checks++;
        if (bus.advance !== 1'b1 || bus.stall_cnt !== cnt_before) begin
            errors++;
            $display("FAIL resume_run: adv=%0b cnt=%0d, required 1 %0d", bus.advance, bus.stall_cnt, cnt_before);
        end
        tick();
        $display("txn halt/resume: stall_cnt=%0d", bus.stall_cnt);
        apply(1, 0, 0, 0, 1, 0, 32'h0, 32'h0);
        tick();
        apply(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        checks++;
        if (bus.halted !== 1'b0 || bus.stall_cnt !== 32'h0 || bus.valid !== 4'h0) begin
            errors++;
            $display("FAIL reset_in_halt: halted=%0b cnt=%0d valid=%b, required 0 0 0000", bus.halted, bus.stall_cnt, bus.valid);
        end
        apply(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        checks++;
        if (bus.pc_write !== 1'b1 || bus.pc !== RVEC) begin
            errors++;
            $display("FAIL reboot: pw=%0b pc=%h, required 1 %h", bus.pc_write, bus.pc, RVEC);
        end
        tick();
        $display("txn reset during halt: halted=%0b", bus.halted);
    endtask

    task automatic test_random();
        logic        rn, st, br, tr, ht, rs;
        logic [31:0] tgt, vec;
        for (int n = 0; n < 400; n++) begin
            rn  = ($urandom % 40) != 0;
            st  = ($urandom % 3) == 0;
            br  = ($urandom % 5) == 0;
            tr  = ($urandom % 10) == 0;
            ht  = ($urandom % 16) == 0;
            rs  = ($urandom % 3) == 0;
            tgt = $urandom & 32'hFFFF_FFFC;
            vec = $urandom & 32'hFFFF_FFFC;
            if (($urandom % 20) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            if (($urandom % 25) == 0) vec = vec | 32'($urandom_range(1, 3));
            apply(rn, st, br, tr, ht, rs, tgt, vec);
            checks++;
            if (bus.advance !== e_adv || bus.pc_write !== e_pw || bus.pc !== e_pc) begin
                errors++;
                $display("FAIL rand_strobe[%0d]: adv=%0b pw=%0b pc=%h, required %0b %0b %h",
                         n, bus.advance, bus.pc_write, bus.pc, e_adv, e_pw, e_pc);
            end
            tick();
            checks++;
            if (bus.valid !== m_valid_vec() || bus.halted !== m_halted || bus.fault !== m_fault ||
                bus.fault_pc !== m_fpc || bus.stall_cnt !== m_cnt) begin
                errors++;
                $display("FAIL rand_regs[%0d]: valid=%b halted=%0b fault=%0b fpc=%h cnt=%0d, required %b %0b %0b %h %0d",
                         n, bus.valid, bus.halted, bus.fault, bus.fault_pc, bus.stall_cnt,
                         m_valid_vec(), m_halted, m_fault, m_fpc, m_cnt);
            end
            $display("txn rand %0d: rst_n=%0b stall=%0b br=%0b trap=%0b halt=%0b res=%0b valid=%b halted=%0b",
                     n, rn, st, br, tr, ht, rs, bus.valid, bus.halted);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch();
        test_trap_priority();
        test_misaligned();
        test_halt_resume();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
